// File: rtl/led_display_sched.sv
// Round-robin time-sharing of the 8-bit LED bank between four pattern sources,
// with a millisecond dwell/blank schedule. Optional build macro: LED_SCHED_OVERRIDE_EN.
module led_display_sched #(
    parameter int   CLK_IN_MHZ   = 125,
    parameter logic LED_POLARITY = 1'b0,
    parameter int   DWELL_MS     = 2000,
    parameter int   BLANK_MS     = 50
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [3:0]  req_i,
    input  logic [31:0] pattern_i,
    input  logic        next_i,
    output logic [7:0]  led_display_o,
    output logic [3:0]  grant_o,
    output logic [1:0]  owner_o
);

    localparam int TICK_CYC = CLK_IN_MHZ * 1000;
    localparam int PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int DW       = (DWELL_MS > 0) ? $clog2(DWELL_MS + 1) : 1;
    localparam int BW       = (BLANK_MS > 0) ? $clog2(BLANK_MS + 1) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYC - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_MS - 1);
    localparam logic [BW-1:0] BLANK_LAST = (BLANK_MS > 0) ? BW'(BLANK_MS - 1) : '0;
    localparam logic [7:0]    LED_OFF    = LED_POLARITY ? 8'h00 : 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    cur_q, cur_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] blank_q, blank_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    led_q, led_d;

    logic       tick;
    logic       any_req;
    logic       others_req;
    logic       advance;
    logic [1:0] pick_idx;
    logic [7:0] show_pattern;

    // First requester scanning cur+1, cur+2, cur+3 and finally cur itself.
    function automatic logic [1:0] pick(input logic [1:0] cur, input logic [3:0] req);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && req[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        presc_d    = tick ? '0 : presc_q + PW'(1);
        any_req    = |req_i;
        others_req = |(req_i & ~(4'b0001 << cur_q));
        advance    = (tick && (dwell_q == DWELL_LAST)) || next_i;
        pick_idx   = pick(cur_q, req_i);

        state_d = state_q;
        cur_d   = cur_q;
        dwell_d = dwell_q;
        blank_d = blank_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_SHOW;
                    cur_d   = pick_idx;
                    dwell_d = '0;
                end
            end
            ST_SHOW: begin
                if (!req_i[cur_q]) begin
                    if (BLANK_MS > 0) begin
                        state_d = ST_BLANK;
                        blank_d = '0;
                    end else if (any_req) begin
                        cur_d   = pick_idx;
                        dwell_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (advance) begin
                    // A lone requester keeps the display without a blank gap.
                    if (others_req && (BLANK_MS > 0)) begin
                        state_d = ST_BLANK;
                        blank_d = '0;
                    end else if (others_req) begin
                        cur_d   = pick_idx;
                        dwell_d = '0;
                    end else begin
                        dwell_d = '0;
                    end
                end else if (tick) begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            ST_BLANK: begin
                if (tick) begin
                    if (blank_q == BLANK_LAST) begin
                        if (any_req) begin
                            state_d = ST_SHOW;
                            cur_d   = pick_idx;
                            dwell_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        blank_d = blank_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef LED_SCHED_OVERRIDE_EN
        // Source 0 pre-empts everything while held; dwell restarts every cycle.
        if (req_i[0]) begin
            state_d = ST_SHOW;
            cur_d   = 2'd0;
            dwell_d = '0;
        end
`endif

        show_pattern = pattern_i[{cur_q, 3'b000} +: 8];
        led_d        = (state_q == ST_SHOW) ? show_pattern : 8'h00;
        if (!LED_POLARITY) begin
            led_d = ~led_d;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cur_q   <= 2'd3;
            dwell_q <= '0;
            blank_q <= '0;
            presc_q <= '0;
            led_q   <= LED_OFF;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dwell_q <= dwell_d;
            blank_q <= blank_d;
            presc_q <= presc_d;
            led_q   <= led_d;
        end
    end

    assign led_display_o = led_q;
    assign grant_o       = (state_q == ST_SHOW) ? (4'b0001 << cur_q) : 4'b0000;
    assign owner_o       = cur_q;

endmodule

// File: tb/tb_led_display_sched.sv
// Directed bench for led_display_sched: 1000 cycles/ms, 4 ms dwell, 1 ms blank,
// active-low LEDs. Timeline is expressed in clock cycles since reset release.
module tb_led_display_sched;

    logic        clk_i;
    logic        rstn_i;
    logic [3:0]  req_i;
    logic [31:0] pattern_i;
    logic        next_i;
    logic [7:0]  led_display_o;
    logic [3:0]  grant_o;
    logic [1:0]  owner_o;

    int n_cmp;
    int n_err;
    int cyc;

    led_display_sched #(
        .CLK_IN_MHZ   (1),
        .LED_POLARITY (1'b0),
        .DWELL_MS     (4),
        .BLANK_MS     (1)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .req_i         (req_i),
        .pattern_i     (pattern_i),
        .next_i        (next_i),
        .led_display_o (led_display_o),
        .grant_o       (grant_o),
        .owner_o       (owner_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Rising edges since reset release; equals the DUT prescaler phase mod 1000.
    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic goto(input int t);
        while (cyc < t) @(negedge clk_i);
    endtask

    task automatic check_gr(input string tag, input logic [3:0] g, input logic [1:0] o);
        check({tag, "_grant"}, {4'h0, grant_o}, {4'h0, g});
        check({tag, "_owner"}, {6'h0, owner_o}, {6'h0, o});
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rstn_i    = 1'b0;
        req_i     = 4'b0000;
        next_i    = 1'b0;
        // source3=F0, source2=3C, source1=81, source0=A5
        pattern_i = 32'hF03C81A5;
        repeat (3) @(negedge clk_i);
        check("rst_led", led_display_o, 8'hFF);
        check_gr("rst", 4'b0000, 2'd3);
        rstn_i = 1'b1;

        // Idle with no requests
        goto(10);    check("idle_led_a", led_display_o, 8'hFF); check_gr("idle_a", 4'b0000, 2'd3);
        goto(9999);  check("idle_led_b", led_display_o, 8'hFF); check_gr("idle_b", 4'b0000, 2'd3);

        // Two-source rotation 0 -> 2 -> 0
        goto(10000); req_i = 4'b0101;
        goto(10001); check_gr("rr_s0", 4'b0001, 2'd0);
        goto(10002); check("rr_s0_led", led_display_o, 8'h5A);
        goto(13999); check_gr("rr_s0_end", 4'b0001, 2'd0);
        goto(14000); check_gr("rr_blank0", 4'b0000, 2'd0);
        goto(14001); check("rr_blank0_led", led_display_o, 8'hFF);
        goto(14999); check_gr("rr_blank0_end", 4'b0000, 2'd0);
        goto(15000); check_gr("rr_s2", 4'b0100, 2'd2);
        goto(15001); check("rr_s2_led", led_display_o, 8'hC3);
        goto(18999); check_gr("rr_s2_end", 4'b0100, 2'd2);
        goto(19000); check_gr("rr_blank2", 4'b0000, 2'd2);
        goto(20000); check_gr("rr_back_s0", 4'b0001, 2'd0);

        // Lone requester keeps the display with no gaps
        req_i = 4'b0010;
        goto(20001); check_gr("solo_drop_blank", 4'b0000, 2'd0);
        goto(21000); check_gr("solo_s1", 4'b0010, 2'd1);
        goto(21001); check("solo_led", led_display_o, 8'h7E);
        goto(31000); check_gr("solo_10ms", 4'b0010, 2'd1);
        goto(41000); check_gr("solo_20ms", 4'b0010, 2'd1);
        check("solo_20ms_led", led_display_o, 8'h7E);

        // next_i forced advance, then requester drop
        req_i = 4'b0001;
        goto(41001); check_gr("nx_drop_blank", 4'b0000, 2'd1);
        goto(42000); check_gr("nx_s0", 4'b0001, 2'd0);
        goto(42500); req_i = 4'b1001; next_i = 1'b1;
        goto(42501); next_i = 1'b0; check_gr("nx_blank", 4'b0000, 2'd0);
        goto(42999); check_gr("nx_blank_end", 4'b0000, 2'd0);
        goto(43000); check_gr("nx_s3", 4'b1000, 2'd3);
        goto(43001); check("nx_s3_led", led_display_o, 8'h0F);
        goto(44500); req_i = 4'b0001;
        goto(44501); check_gr("drop3_blank", 4'b0000, 2'd3);
        goto(44700); next_i = 1'b1;
        goto(44701); next_i = 1'b0;
        goto(44999); check_gr("blank_ignores_next", 4'b0000, 2'd3);
        check("blank_led", led_display_o, 8'hFF);
        goto(45000); check_gr("drop3_s0", 4'b0001, 2'd0);

        // Reset asserted mid-blank
        req_i = 4'b0101;
        goto(48999); check_gr("pre_rst_s0", 4'b0001, 2'd0);
        goto(49000); check_gr("pre_rst_blank", 4'b0000, 2'd0);
        goto(49500);
        rstn_i = 1'b0;
        #1;
        check("async_rst_led", led_display_o, 8'hFF);
        check_gr("async_rst", 4'b0000, 2'd3);
        req_i = 4'b0110;
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        goto(1); check_gr("post_rst_s1", 4'b0010, 2'd1);
        goto(2); check("post_rst_led", led_display_o, 8'h7E);

`ifdef LED_SCHED_OVERRIDE_EN
        // Source 0 pre-empts the owner of source 2
        goto(10); req_i = 4'b0100;
        goto(1000); check_gr("ov_s2", 4'b0100, 2'd2);
        goto(1500); req_i = 4'b0101;
        goto(1501); check_gr("ov_take", 4'b0001, 2'd0);
        goto(1502); check("ov_led", led_display_o, 8'h5A);
        goto(3000); next_i = 1'b1;
        goto(3001); next_i = 1'b0;
        goto(11500); check_gr("ov_held", 4'b0001, 2'd0);
        req_i = 4'b0100;
        goto(11501); check_gr("ov_rel_blank", 4'b0000, 2'd0);
        goto(12000); check_gr("ov_rel_s2", 4'b0100, 2'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
